// File: rtl/MIPS_pkg.sv
// ---------------------------------------------------------------------------
// MIPS_pkg -- shared widths, MMIO offset map and timer control layout.
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package MIPS_pkg;

    localparam int MIPS_PC_WIDTH     = 32;
    localparam int MIPS_DATA_WIDTH   = 32;
    localparam int MIPS_MMIO_SEL_BIT = MIPS_PC_WIDTH - 1;
    localparam int MIPS_MMIO_OFF_W   = 3;

    typedef enum logic [MIPS_MMIO_OFF_W-1:0] {
        MMIO_LED    = 3'd0,
        MMIO_SW     = 3'd1,
        MMIO_CYCLE  = 3'd2,
        MMIO_TLOAD  = 3'd3,
        MMIO_TCTRL  = 3'd4,
        MMIO_TSTAT  = 3'd5,
        MMIO_TCOUNT = 3'd6,
        MMIO_RSVD   = 3'd7
    } mips_mmio_off_e;

    // Packed so that enable lands on bit0 and autoreload on bit1 of TCTRL.
    typedef struct packed {
        logic autoreload;
        logic enable;
    } mips_tctrl_t;

    function automatic logic mips_is_mmio(input logic [MIPS_PC_WIDTH-1:0] addr);
        return addr[MIPS_MMIO_SEL_BIT];
    endfunction

endpackage

`default_nettype wire

// File: rtl/mips_timer.sv
// ---------------------------------------------------------------------------
// mips_timer -- down-counting timer with optional auto-reload and sticky expiry.
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mips_timer
    import MIPS_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_tload_i,
    input  logic                       wr_tctrl_i,
    input  logic                       wr_tstat_i,
    input  logic [MIPS_DATA_WIDTH-1:0] wr_data_i,
    output logic [MIPS_DATA_WIDTH-1:0] tload_o,
    output mips_tctrl_t                tctrl_o,
    output logic [MIPS_DATA_WIDTH-1:0] tcount_o,
    output logic                       expired_o
);

    logic [MIPS_DATA_WIDTH-1:0] tload_q, tload_d;
    logic [MIPS_DATA_WIDTH-1:0] tcount_q, tcount_d;
    mips_tctrl_t                tctrl_q, tctrl_d;
    logic                       expired_q, expired_d;
    logic                       expire_evt;

    always_comb begin
        tload_d    = tload_q;
        tctrl_d    = tctrl_q;
        tcount_d   = tcount_q;
        expired_d  = expired_q;
        expire_evt = 1'b0;

        if (wr_tload_i) begin
            tload_d = wr_data_i;
        end
        if (wr_tctrl_i) begin
            tctrl_d = mips_tctrl_t'(wr_data_i[1:0]);
        end

        // A TLOAD write overrides the countdown, so it also suppresses expiry.
        if (wr_tload_i) begin
            tcount_d = wr_data_i;
        end else if (tctrl_q.enable && (tcount_q != '0)) begin
            if (tcount_q == 32'd1) begin
                expire_evt = 1'b1;
                tcount_d   = tctrl_q.autoreload ? tload_q : '0;
            end else begin
                tcount_d = tcount_q - 32'd1;
            end
        end

        if (wr_tstat_i && wr_data_i[0]) begin
            expired_d = 1'b0;
        end
        if (expire_evt) begin
            expired_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tload_q   <= '0;
            tctrl_q   <= '0;
            tcount_q  <= '0;
            expired_q <= 1'b0;
        end else begin
            tload_q   <= tload_d;
            tctrl_q   <= tctrl_d;
            tcount_q  <= tcount_d;
            expired_q <= expired_d;
        end
    end

    assign tload_o   = tload_q;
    assign tctrl_o   = tctrl_q;
    assign tcount_o  = tcount_q;
    assign expired_o = expired_q;

endmodule

`default_nettype wire

// File: rtl/mips_mem_responder.sv
// ---------------------------------------------------------------------------
// mips_mem_responder -- zero-latency RAM plus MMIO block (LED, SW, CYCLE, timer).
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mips_mem_responder
    import MIPS_pkg::*;
#(
    parameter int    RAM_DEPTH = 1024,
    parameter string INIT_FILE = ""
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [MIPS_PC_WIDTH-1:0]   addr_mem,
    input  logic [MIPS_DATA_WIDTH-1:0] wr_data_mem,
    input  logic                       wr_en_mem,
    output logic [MIPS_DATA_WIDTH-1:0] rd_data_mem,
    input  logic [15:0]                sw_i,
    output logic [15:0]                led_o,
    output logic                       timer_irq
);

    localparam int RAM_AW = $clog2(RAM_DEPTH);

    logic [MIPS_DATA_WIDTH-1:0] mem_q [RAM_DEPTH];

    logic [RAM_AW-1:0]          ram_idx;
    mips_mmio_off_e             mmio_off;
    logic                       sel_mmio;
    logic                       wr_ok;
    logic                       ram_we;
    logic                       mmio_we;
    logic                       unused_addr_bits;

    assign ram_idx          = addr_mem[RAM_AW-1:0];
    assign mmio_off         = mips_mmio_off_e'(addr_mem[MIPS_MMIO_OFF_W-1:0]);
    assign sel_mmio         = mips_is_mmio(addr_mem);
    assign unused_addr_bits = ^addr_mem[MIPS_MMIO_SEL_BIT-1:RAM_AW];

    // Reset blocks every bus write, RAM included.
    assign wr_ok   = wr_en_mem & rst_n;
    assign ram_we  = wr_ok & ~sel_mmio;
    assign mmio_we = wr_ok & sel_mmio;

    always_ff @(posedge clk) begin
        if (ram_we) begin
            mem_q[ram_idx] <= wr_data_mem;
        end
    end

    logic                       wr_led, wr_cycle, wr_tload, wr_tctrl, wr_tstat;
    logic [15:0]                led_q, led_d;
    logic [MIPS_DATA_WIDTH-1:0] cycle_q, cycle_d;

    assign wr_led   = mmio_we && (mmio_off == MMIO_LED);
    assign wr_cycle = mmio_we && (mmio_off == MMIO_CYCLE);
    assign wr_tload = mmio_we && (mmio_off == MMIO_TLOAD);
    assign wr_tctrl = mmio_we && (mmio_off == MMIO_TCTRL);
    assign wr_tstat = mmio_we && (mmio_off == MMIO_TSTAT);

    always_comb begin
        led_d   = wr_led ? wr_data_mem[15:0] : led_q;
        cycle_d = wr_cycle ? '0 : (cycle_q + 32'd1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            led_q   <= '0;
            cycle_q <= '0;
        end else begin
            led_q   <= led_d;
            cycle_q <= cycle_d;
        end
    end

    logic [MIPS_DATA_WIDTH-1:0] tload, tcount;
    mips_tctrl_t                tctrl;
    logic                       expired;

    mips_timer u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_tload_i (wr_tload),
        .wr_tctrl_i (wr_tctrl),
        .wr_tstat_i (wr_tstat),
        .wr_data_i  (wr_data_mem),
        .tload_o    (tload),
        .tctrl_o    (tctrl),
        .tcount_o   (tcount),
        .expired_o  (expired)
    );

    logic [MIPS_DATA_WIDTH-1:0] mmio_rdata;

    always_comb begin
        mmio_rdata = '0;
        case (mmio_off)
            MMIO_LED:    mmio_rdata = {16'h0000, led_q};
            MMIO_SW:     mmio_rdata = {16'h0000, sw_i};
            MMIO_CYCLE:  mmio_rdata = cycle_q;
            MMIO_TLOAD:  mmio_rdata = tload;
            MMIO_TCTRL:  mmio_rdata = {30'd0, tctrl};
            MMIO_TSTAT:  mmio_rdata = {31'd0, expired};
            MMIO_TCOUNT: mmio_rdata = tcount;
            default:     mmio_rdata = '0;
        endcase
        rd_data_mem = sel_mmio ? mmio_rdata : mem_q[ram_idx];
    end

    assign led_o     = led_q;
    assign timer_irq = expired;

endmodule

`default_nettype wire

// File: tb/tb_mips_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_mips_mem_responder -- scoreboard-driven bench for RAM, MMIO and timer.
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_mips_mem_responder;

    localparam int          DEPTH  = 16;
    localparam logic [31:0] A_LED  = 32'h8000_0000;
    localparam logic [31:0] A_SW   = 32'h8000_0001;
    localparam logic [31:0] A_CYC  = 32'h8000_0002;
    localparam logic [31:0] A_TLD  = 32'h8000_0003;
    localparam logic [31:0] A_TCTL = 32'h8000_0004;
    localparam logic [31:0] A_TST  = 32'h8000_0005;
    localparam logic [31:0] A_TCNT = 32'h8000_0006;
    localparam logic [31:0] A_RSVD = 32'h8000_0007;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] addr_mem;
    logic [31:0] wr_data_mem;
    logic        wr_en_mem;
    logic [31:0] rd_data_mem;
    logic [15:0] sw_i;
    logic [15:0] led_o;
    logic        timer_irq;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] exp_q [$];

    mips_mem_responder #(.RAM_DEPTH(DEPTH), .INIT_FILE("")) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .addr_mem    (addr_mem),
        .wr_data_mem (wr_data_mem),
        .wr_en_mem   (wr_en_mem),
        .rd_data_mem (rd_data_mem),
        .sw_i        (sw_i),
        .led_o       (led_o),
        .timer_irq   (timer_irq)
    );

    always #50 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    // Push the expectation, let the combinational read settle, then score it.
    task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string tag);
        exp_q.push_back(exp);
        addr_mem = a;
        #1;
        check_eq(tag, rd_data_mem, exp_q.pop_front());
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        addr_mem    = a;
        wr_data_mem = d;
        wr_en_mem   = 1'b1;
        @(negedge clk);
        wr_en_mem   = 1'b0;
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst_n       = 1'b0;
        addr_mem    = '0;
        wr_data_mem = '0;
        wr_en_mem   = 1'b0;
        sw_i        = '0;
        step(2);
        rst_n = 1'b1;

        check_eq("rst_led_o", {16'h0, led_o}, 32'h0);
        check_eq("rst_irq", {31'h0, timer_irq}, 32'h0);
        rd(A_LED, 32'h0, "rst_led");
        rd(A_TLD, 32'h0, "rst_tload");
        rd(A_TCTL, 32'h0, "rst_tctrl");
        rd(A_TST, 32'h0, "rst_tstat");
        rd(A_TCNT, 32'h0, "rst_tcount");
        rd(A_RSVD, 32'h0, "rst_rsvd");

        rd(A_CYC, 32'd0, "cyc0");
        step(1);
        rd(A_CYC, 32'd1, "cyc1");
        step(1);
        rd(A_CYC, 32'd2, "cyc2");
        wr(A_CYC, 32'h1234_5678);
        rd(A_CYC, 32'd0, "cyc_wr0");
        step(1);
        rd(A_CYC, 32'd1, "cyc_wr1");
        force dut.cycle_q = 32'hFFFF_FFFF;
        #1;
        rd(A_CYC, 32'hFFFF_FFFF, "cyc_max");
        release dut.cycle_q;
        step(1);
        rd(A_CYC, 32'd0, "cyc_wrap");

        wr(32'd5, 32'h1111_1111);
        wr(32'd6, 32'h0BAD_F00D);
        addr_mem    = 32'd5;
        wr_data_mem = 32'hDEAD_BEEF;
        wr_en_mem   = 1'b1;
        #1;
        exp_q.push_back(32'h1111_1111);
        check_eq("ram_same_cycle", rd_data_mem, exp_q.pop_front());
        @(negedge clk);
        wr_en_mem = 1'b0;
        rd(32'd5, 32'hDEAD_BEEF, "ram_next");
        rd(32'd5 + DEPTH, 32'hDEAD_BEEF, "ram_alias");
        rd(32'd6, 32'h0BAD_F00D, "ram_other");

        wr(A_LED, 32'h0001_A5A5);
        check_eq("led_o", {16'h0, led_o}, 32'h0000_A5A5);
        rd(A_LED, 32'h0000_A5A5, "led_rd");
        sw_i = 16'h1234;
        rd(A_SW, 32'h0000_1234, "sw_rd");
        wr(A_SW, 32'hFFFF_FFFF);
        rd(A_SW, 32'h0000_1234, "sw_ro");
        wr(A_RSVD, 32'hFFFF_FFFF);
        rd(A_RSVD, 32'h0, "rsvd_ro");
        check_eq("led_kept", {16'h0, led_o}, 32'h0000_A5A5);

        wr(A_TLD, 32'd3);
        rd(A_TLD, 32'd3, "os_tload");
        wr(A_TCTL, 32'h1);
        rd(A_TCTL, 32'h1, "os_tctrl");
        rd(A_TCNT, 32'd3, "os_c3");
        step(1);
        rd(A_TCNT, 32'd2, "os_c2");
        step(1);
        rd(A_TCNT, 32'd1, "os_c1");
        check_eq("os_irq_lo", {31'h0, timer_irq}, 32'h0);
        step(1);
        rd(A_TCNT, 32'd0, "os_c0");
        check_eq("os_irq_hi", {31'h0, timer_irq}, 32'h1);
        step(2);
        rd(A_TCNT, 32'd0, "os_hold");
        rd(A_TST, 32'h1, "os_tstat");
        wr(A_TST, 32'h1);
        check_eq("os_irq_clr", {31'h0, timer_irq}, 32'h0);
        wr(A_TCTL, 32'h0);

        wr(A_TLD, 32'd2);
        wr(A_TCTL, 32'h3);
        rd(A_TCNT, 32'd2, "ar_c2a");
        step(1);
        rd(A_TCNT, 32'd1, "ar_c1a");
        step(1);
        rd(A_TCNT, 32'd2, "ar_c2b");
        check_eq("ar_irq", {31'h0, timer_irq}, 32'h1);
        wr(A_TST, 32'h1);
        rd(A_TCNT, 32'd1, "ar_c1b");
        check_eq("ar_irq_clr", {31'h0, timer_irq}, 32'h0);
        wr(A_TST, 32'h1);
        rd(A_TCNT, 32'd2, "ar_c2c");
        check_eq("ar_set_wins", {31'h0, timer_irq}, 32'h1);
        wr(A_TCTL, 32'h0);
        rd(A_TCNT, 32'd1, "frz_c1");
        step(3);
        rd(A_TCNT, 32'd1, "frz_hold");
        check_eq("frz_irq", {31'h0, timer_irq}, 32'h1);

        wr(A_TLD, 32'd100);
        wr(A_TCTL, 32'h1);
        step(2);
        rd(A_TCNT, 32'd98, "mid_c98");
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check_eq("mid_led_o", {16'h0, led_o}, 32'h0);
        check_eq("mid_irq", {31'h0, timer_irq}, 32'h0);
        rd(A_LED, 32'h0, "mid_led");
        rd(A_CYC, 32'h0, "mid_cyc");
        rd(A_TLD, 32'h0, "mid_tload");
        rd(A_TCTL, 32'h0, "mid_tctrl");
        rd(A_TST, 32'h0, "mid_tstat");
        rd(A_TCNT, 32'h0, "mid_tcount");
        rd(32'd5, 32'hDEAD_BEEF, "mid_ram5");
        rd(32'd6, 32'h0BAD_F00D, "mid_ram6");
        step(3);
        rd(A_TCNT, 32'h0, "mid_idle");
        check_eq("mid_irq_idle", {31'h0, timer_irq}, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
